// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS MEM stage: memory opcodes, access sizing,
// FSM encoding and the value returned by an aborted access.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] DEADBEEF_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unknown opcodes that still touch memory are treated as word accesses.
    function automatic acc_size_t access_size(input logic [5:0] opcode);
        case (opcode)
            OP_LB, OP_LBU, OP_SB: access_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: access_size = SZ_HALF;
            OP_LW, OP_SW:         access_size = SZ_WORD;
            default:              access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian load alignment: picks the addressed byte/half out of a memory
// word and sign- or zero-extends it according to the load opcode.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] ld_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Byte offset 0 is the most significant lane.
        case (addr)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[15:0] : rdata[31:16];

        case (opcode)
            OP_LB:   ld_value = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_value = {24'h000000, byte_sel};
            OP_LH:   ld_value = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_value = {16'h0000, half_sel};
            default: ld_value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory req/ack access, upstream FREEZE, MEM/WB register
// and MEM forwarding. Define MEM_TIMEOUT_EN to add the WAIT-state watchdog.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instr1_PR,
    input  logic [31:0]       aluResult1_PR,
    input  logic [31:0]       readDataB1_PR,
    input  logic [4:0]        writeRegister1_PR,
    input  logic              MemRead1_PR,
    input  logic              MemWrite1_PR,
    input  logic              MemtoReg1_PR,
    input  logic              do_writeback1_PR,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              FREEZE,
    output logic [31:0]       Data1_MEM,
    output logic [4:0]        writeRegister1_MEM,
    output logic              do_writeback1_MEM,
    output logic [31:0]       Data1_WB,
    output logic [4:0]        writeRegister1_WB,
    output logic              do_writeback1_WB,
    output logic              misalign_err
);

    mem_state_t  state_q, state_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] data1_wb_q, data1_wb_d;
    logic [4:0]  wreg_wb_q, wreg_wb_d;
    logic        dowb_wb_q, dowb_wb_d;

    logic [5:0]  opcode;
    acc_size_t   acc_size;
    logic [1:0]  boff;
    logic        aligned, mem_access, mem_op, misalign;
    logic        freeze_c, req_c;
    logic        timeout_hit, abort_done;
    logic [31:0] ld_aligned;
    logic        unused_bits;

    assign opcode      = Instr1_PR[31:26];
    assign acc_size    = access_size(opcode);
    assign boff        = aluResult1_PR[1:0];
    assign unused_bits = ^Instr1_PR[25:0];

    always_comb begin
        case (acc_size)
            SZ_HALF: aligned = ~boff[0];
            SZ_WORD: aligned = (boff == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign mem_access = MemRead1_PR | MemWrite1_PR;
    assign mem_op     = mem_access & aligned;
    assign misalign   = mem_access & ~aligned;

    // Request fields come straight from EXE/MEM, which FREEZE holds steady in WAIT.
    assign dmem_we   = MemWrite1_PR;
    assign dmem_addr = {aluResult1_PR[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = readDataB1_PR;
        case (acc_size)
            SZ_BYTE: begin
                dmem_be    = 4'b1000 >> boff;
                dmem_wdata = {4{readDataB1_PR[7:0]}};
            end
            SZ_HALF: begin
                dmem_be    = boff[1] ? 4'b0011 : 4'b1100;
                dmem_wdata = {2{readDataB1_PR[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .rdata    (dmem_rdata),
        .addr     (boff),
        .opcode   (opcode),
        .ld_value (ld_aligned)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             aborted_q, aborted_d;

    assign timeout_hit = (state_q == ST_WAIT) && !dmem_ack &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign aborted_d   = timeout_hit;
    assign abort_done  = aborted_q && (state_q == ST_DONE);

    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_WAIT && !dmem_ack)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_cnt_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            aborted_q <= aborted_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES != 0);
    assign timeout_hit = 1'b0;
    assign abort_done  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ld_data_d = ld_data_q;
        req_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    req_c = 1'b1;
                    if (dmem_ack) begin
                        ld_data_d = ld_aligned;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    ld_data_d = ld_aligned;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with RESET drops req/freeze the moment reset is asserted.
    assign freeze_c     = mem_op & (state_q != ST_DONE);
    assign FREEZE       = freeze_c & RESET;
    assign dmem_req     = req_c & RESET;
    assign misalign_err = (misalign | abort_done) & RESET;

    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

    // A frozen cycle hands WB a bubble; the real result goes in on the DONE edge.
    always_comb begin
        data1_wb_d = MemtoReg1_PR ? ld_data_q : aluResult1_PR;
        wreg_wb_d  = writeRegister1_PR;
        dowb_wb_d  = do_writeback1_PR & ~MemWrite1_PR;
        if (freeze_c || misalign) begin
            data1_wb_d = 32'h0;
            dowb_wb_d  = 1'b0;
        end else if (abort_done) begin
            data1_wb_d = DEADBEEF_DATA;
            dowb_wb_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            ld_data_q  <= 32'h0;
            data1_wb_q <= 32'h0;
            wreg_wb_q  <= 5'd0;
            dowb_wb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_data_q  <= ld_data_d;
            data1_wb_q <= data1_wb_d;
            wreg_wb_q  <= wreg_wb_d;
            dowb_wb_q  <= dowb_wb_d;
        end
    end

    assign Data1_WB          = data1_wb_q;
    assign writeRegister1_WB = wreg_wb_q;
    assign do_writeback1_WB  = dowb_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver plays upstream pipeline and data
// memory, a monitor checks requests, MEM/WB results, stalls and error pulses.
module tb_mem_stage;
    import mips_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_PR, aluResult1_PR, readDataB1_PR;
    logic [4:0]  writeRegister1_PR;
    logic        MemRead1_PR, MemWrite1_PR, MemtoReg1_PR, do_writeback1_PR;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        FREEZE, do_writeback1_MEM, do_writeback1_WB, misalign_err;
    logic [31:0] Data1_MEM, Data1_WB;
    logic [4:0]  writeRegister1_MEM, writeRegister1_WB;

    mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_PR(Instr1_PR), .aluResult1_PR(aluResult1_PR),
        .readDataB1_PR(readDataB1_PR), .writeRegister1_PR(writeRegister1_PR),
        .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR),
        .MemtoReg1_PR(MemtoReg1_PR), .do_writeback1_PR(do_writeback1_PR),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .FREEZE(FREEZE),
        .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM),
        .do_writeback1_MEM(do_writeback1_MEM),
        .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB),
        .do_writeback1_WB(do_writeback1_WB), .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  wreg;
        logic        wb;
        logic [7:0]  frz;
        logic [7:0]  err;
        logic [31:0] fdata;
        logic [4:0]  freg;
        logic        fwb;
    } wb_exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    logic     slot_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic wb_exp_t mk_wb(input logic [31:0] data, input logic [4:0] wreg,
                                      input logic wb, input int frz, input int err,
                                      input logic [31:0] fdata, input logic [4:0] freg,
                                      input logic fwb);
        wb_exp_t e;
        e.data = data; e.wreg = wreg; e.wb = wb; e.frz = 8'(frz); e.err = 8'(err);
        e.fdata = fdata; e.freg = freg; e.fwb = fwb;
        return e;
    endfunction

    function automatic req_exp_t mk_req(input logic we, input logic [31:0] addr,
                                        input logic [3:0] be, input logic [31:0] wdata);
        req_exp_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
        return r;
    endfunction

    task automatic drive_bubble();
        Instr1_PR = 32'h0; aluResult1_PR = 32'h0; readDataB1_PR = 32'h0;
        writeRegister1_PR = 5'd0; MemRead1_PR = 1'b0; MemWrite1_PR = 1'b0;
        MemtoReg1_PR = 1'b0; do_writeback1_PR = 1'b0; slot_valid = 1'b0;
    endtask

    // Present one instruction, acknowledge after dly unacked request cycles,
    // return once the stage has advanced past it (called at posedge+1).
    task automatic run(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] b,
                       input logic [4:0] wr, input logic mr, input logic mw,
                       input logic m2r, input logic dw, input int dly,
                       input logic [31:0] rd, input wb_exp_t e,
                       input bit has_req, input req_exp_t r);
        int  waited;
        bit  adv, done;
        if (has_req) req_q.push_back(r);
        wb_q.push_back(e);
        Instr1_PR = {op, 26'h0}; aluResult1_PR = alu; readDataB1_PR = b;
        writeRegister1_PR = wr; MemRead1_PR = mr; MemWrite1_PR = mw;
        MemtoReg1_PR = m2r; do_writeback1_PR = dw; slot_valid = 1'b1;
        waited = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            adv = !FREEZE;
            if (dmem_req) begin
                if (waited == dly) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rd;
                end else begin
                    waited++;
                end
            end
            @(posedge CLK);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = 32'h0;
            done = adv;
        end
        if (!done) chk("stage_advance_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: request fields on each new request, MEM/WB after each advance.
    initial begin : monitor
        int      frz, err, frz_done, err_done;
        bit      pend, req_prev;
        wb_exp_t e, cur;
        req_exp_t r;
        frz = 0; err = 0; frz_done = 0; err_done = 0; pend = 1'b0; req_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET !== 1'b1) begin
                pend = 1'b0; frz = 0; err = 0; req_prev = 1'b0;
                continue;
            end
            if (pend) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk("Data1_WB", Data1_WB, e.data);
                    chk("writeRegister1_WB", 32'(writeRegister1_WB), 32'(e.wreg));
                    chk("do_writeback1_WB", 32'(do_writeback1_WB), 32'(e.wb));
                    chk("freeze_cycles", 32'(frz_done), 32'(e.frz));
                    chk("misalign_err_cycles", 32'(err_done), 32'(e.err));
                end
                pend = 1'b0;
            end
            if (slot_valid) begin
                if (FREEZE) frz++;
                if (misalign_err) err++;
                if (!FREEZE && wb_q.size() != 0) begin
                    cur = wb_q[0];
                    chk("Data1_MEM", Data1_MEM, cur.fdata);
                    chk("writeRegister1_MEM", 32'(writeRegister1_MEM), 32'(cur.freg));
                    chk("do_writeback1_MEM", 32'(do_writeback1_MEM), 32'(cur.fwb));
                    pend = 1'b1; frz_done = frz; err_done = err; frz = 0; err = 0;
                end
            end else if (misalign_err) begin
                chk("misalign_err_idle", 32'(misalign_err), 32'd0);
            end
            if (dmem_req && !req_prev) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'(dmem_req), 32'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("dmem_we", 32'(dmem_we), 32'(r.we));
                    chk("dmem_addr", dmem_addr, r.addr);
                    chk("dmem_be", 32'(dmem_be), 32'(r.be));
                    chk("dmem_wdata", dmem_wdata, r.wdata);
                end
            end
            req_prev = dmem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        req_exp_t no_req;
        no_req = mk_req(1'b0, 32'h0, 4'h0, 32'h0);
        RESET = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive_bubble();

        @(negedge CLK);
        chk("rst_Data1_WB", Data1_WB, 32'h0);
        chk("rst_do_writeback1_WB", 32'(do_writeback1_WB), 32'd0);
        chk("rst_writeRegister1_WB", 32'(writeRegister1_WB), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_FREEZE", 32'(FREEZE), 32'd0);
        chk("rst_misalign_err", 32'(misalign_err), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        // LW, zero-wait ack
        run(OP_LW, 32'h100, 32'h0, 5'd8, 1, 0, 1, 1, 0, 32'h11223344,
            mk_wb(32'h11223344, 5'd8, 1, 1, 0, 32'h100, 5'd8, 0),
            1, mk_req(1'b0, 32'h100, 4'b1111, 32'h0));
        // LB / LBU at byte offset 3, three unacked request cycles
        run(OP_LB, 32'h103, 32'h0, 5'd9, 1, 0, 1, 1, 3, 32'h112233F0,
            mk_wb(32'hFFFFFFF0, 5'd9, 1, 4, 0, 32'h103, 5'd9, 0),
            1, mk_req(1'b0, 32'h100, 4'b0001, 32'h0));
        run(OP_LBU, 32'h103, 32'h0, 5'd10, 1, 0, 1, 1, 3, 32'h112233F0,
            mk_wb(32'h000000F0, 5'd10, 1, 4, 0, 32'h103, 5'd10, 0),
            1, mk_req(1'b0, 32'h100, 4'b0001, 32'h0));
        // SH to the low half; writeback request must be suppressed
        run(OP_SH, 32'h202, 32'h0000ABCD, 5'd0, 0, 1, 0, 1, 1, 32'h0,
            mk_wb(32'h202, 5'd0, 0, 2, 0, 32'h202, 5'd0, 1),
            1, mk_req(1'b1, 32'h200, 4'b0011, 32'hABCDABCD));
        run(OP_SB, 32'h301, 32'h1234565A, 5'd0, 0, 1, 0, 0, 0, 32'h0,
            mk_wb(32'h301, 5'd0, 0, 1, 0, 32'h301, 5'd0, 0),
            1, mk_req(1'b1, 32'h300, 4'b0100, 32'h5A5A5A5A));
        run(OP_LH, 32'h402, 32'h0, 5'd11, 1, 0, 1, 1, 2, 32'h12348765,
            mk_wb(32'hFFFF8765, 5'd11, 1, 3, 0, 32'h402, 5'd11, 0),
            1, mk_req(1'b0, 32'h400, 4'b0011, 32'h0));
        run(OP_LHU, 32'h400, 32'h0, 5'd12, 1, 0, 1, 1, 0, 32'h87651234,
            mk_wb(32'h00008765, 5'd12, 1, 1, 0, 32'h400, 5'd12, 0),
            1, mk_req(1'b0, 32'h400, 4'b1100, 32'h0));
        // Misaligned word load and half load: no request, one-cycle error
        run(OP_LW, 32'h101, 32'h0, 5'd13, 1, 0, 1, 1, 0, 32'h0,
            mk_wb(32'h0, 5'd13, 0, 0, 1, 32'h101, 5'd13, 0), 0, no_req);
        run(OP_LH, 32'h403, 32'h0, 5'd14, 1, 0, 1, 1, 0, 32'h0,
            mk_wb(32'h0, 5'd14, 0, 0, 1, 32'h403, 5'd14, 0), 0, no_req);
        // ALU op forwards and writes back with no stall
        run(6'h00, 32'h55, 32'h0, 5'd5, 0, 0, 0, 1, 0, 32'h0,
            mk_wb(32'h55, 5'd5, 1, 0, 0, 32'h55, 5'd5, 1), 0, no_req);
        run(OP_SW, 32'h500, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0, 1, 32'h0,
            mk_wb(32'h500, 5'd0, 0, 2, 0, 32'h500, 5'd0, 0),
            1, mk_req(1'b1, 32'h500, 4'b1111, 32'hCAFEF00D));
        run(OP_SW, 32'h206, 32'h12345678, 5'd0, 0, 1, 0, 0, 0, 32'h0,
            mk_wb(32'h0, 5'd0, 0, 0, 1, 32'h206, 5'd0, 0), 0, no_req);
        drive_bubble();
        repeat (3) @(posedge CLK);
        #1;

        // Reset asserted while a load sits in WAIT
        req_q.push_back(mk_req(1'b0, 32'h600, 4'b1111, 32'h0));
        Instr1_PR = {OP_LW, 26'h0}; aluResult1_PR = 32'h600;
        writeRegister1_PR = 5'd7; MemRead1_PR = 1'b1; MemtoReg1_PR = 1'b1;
        do_writeback1_PR = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        chk("wait_FREEZE", 32'(FREEZE), 32'd1);
        chk("wait_dmem_req", 32'(dmem_req), 32'd1);
        RESET = 1'b0;
        #1;
        chk("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_FREEZE", 32'(FREEZE), 32'd0);
        drive_bubble();
        @(posedge CLK); #1;
        RESET = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h77777777;
        repeat (2) begin
            @(negedge CLK);
            chk("late_ack_do_writeback1_WB", 32'(do_writeback1_WB), 32'd0);
            chk("late_ack_Data1_WB", Data1_WB, 32'h0);
            chk("late_ack_dmem_req", 32'(dmem_req), 32'd0);
        end
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(negedge CLK);

        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
